// File: rtl/axi_lite_sim_mem_responder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_lite_sim_mem_responder_if : reduced AXI-lite AR/R, AW/W/B channel bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
interface axi_lite_sim_mem_responder_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;

  modport master (
    output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, awready, wready, bvalid
  );

  modport slave (
    input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, awready, wready, bvalid
  );
endinterface
`default_nettype wire

// File: rtl/axi_lite_sim_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_lite_sim_mem_responder : word-addressed AXI-lite memory slave for sims
// Revision: 1.0
// ---------------------------------------------------------------------------
module axi_lite_sim_mem_responder #(
  parameter int unsigned DEPTH_WORDS  = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] OOR_RDATA    = 32'hDEAD_BEEF
) (
  input  wire logic                   clk_i,
  input  wire logic                   rst_i,
  axi_lite_sim_mem_responder_if.slave s_axi
);

  localparam int unsigned c_idx_w     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] c_mem_bytes = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  c_lat_init  = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_WAIT = 2'd1, RD_RESP = 2'd2} rd_state_t;
  typedef enum logic [0:0] {WR_IDLE = 1'b0, WR_BRESP = 1'b1} wr_state_t;

  // Left without reset so a testbench memory preload survives rst_i.
  logic [31:0] r_mem [DEPTH_WORDS];

  function automatic logic in_range(input logic [31:0] addr);
    return (addr - BASE_ADDR) < c_mem_bytes;
  endfunction

  function automatic logic [c_idx_w-1:0] word_idx(input logic [31:0] addr);
    return c_idx_w'((addr - BASE_ADDR) >> 2);
  endfunction

  // ---------------- read engine ----------------
  rd_state_t   r_rd_state, w_rd_state_nxt;
  logic [3:0]  r_rd_cnt, w_rd_cnt_nxt;
  logic        r_arready, w_arready_nxt;
  logic        r_rvalid, w_rvalid_nxt;
  logic [31:0] r_araddr, r_rdata, w_rd_addr;
  logic        w_ar_hs, w_rd_sample;

  // With single-cycle latency the sample happens on the handshake edge itself.
  assign w_rd_addr = (r_rd_state == RD_IDLE) ? s_axi.araddr : r_araddr;

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_cnt_nxt   = r_rd_cnt;
    w_arready_nxt  = r_arready;
    w_rvalid_nxt   = r_rvalid;
    w_ar_hs        = 1'b0;
    w_rd_sample    = 1'b0;
    case (r_rd_state)
      RD_IDLE: begin
        w_arready_nxt = 1'b1;
        if (s_axi.arvalid && r_arready) begin
          w_ar_hs       = 1'b1;
          w_arready_nxt = 1'b0;
          w_rd_cnt_nxt  = c_lat_init;
          if (READ_LATENCY == 1) begin
            w_rd_state_nxt = RD_RESP;
            w_rd_sample    = 1'b1;
            w_rvalid_nxt   = 1'b1;
          end else begin
            w_rd_state_nxt = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        w_rd_cnt_nxt = r_rd_cnt - 4'd1;
        if (r_rd_cnt == 4'd1) begin
          w_rd_state_nxt = RD_RESP;
          w_rd_sample    = 1'b1;
          w_rvalid_nxt   = 1'b1;
        end
      end
      RD_RESP: begin
        if (s_axi.rready) begin
          w_rd_state_nxt = RD_IDLE;
          w_rvalid_nxt   = 1'b0;
          w_arready_nxt  = 1'b1;
        end
      end
      default: w_rd_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_state <= RD_IDLE;
      r_rd_cnt   <= 4'd0;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_araddr   <= 32'd0;
      r_rdata    <= 32'd0;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_rd_cnt   <= w_rd_cnt_nxt;
      r_arready  <= w_arready_nxt;
      r_rvalid   <= w_rvalid_nxt;
      if (w_ar_hs) r_araddr <= s_axi.araddr;
      if (w_rd_sample)
        r_rdata <= in_range(w_rd_addr) ? r_mem[word_idx(w_rd_addr)] : OOR_RDATA;
    end
  end

  // ---------------- write engine ----------------
  wr_state_t   r_wr_state, w_wr_state_nxt;
  logic        r_awready, w_awready_nxt, r_wready, w_wready_nxt;
  logic        r_bvalid, w_bvalid_nxt;
  logic        r_aw_full, w_aw_full_nxt, r_w_full, w_w_full_nxt;
  logic [31:0] r_awaddr, r_wdata;
  logic [3:0]  r_wstrb;
  logic        w_aw_hs, w_w_hs, w_commit;
  logic [31:0] w_wr_addr, w_wr_data;
  logic [3:0]  w_wr_strb;

  assign w_aw_hs   = s_axi.awvalid && r_awready;
  assign w_w_hs    = s_axi.wvalid && r_wready;
  // Buffered values take priority; otherwise the live bus completes this cycle.
  assign w_wr_addr = r_aw_full ? r_awaddr : s_axi.awaddr;
  assign w_wr_data = r_w_full  ? r_wdata  : s_axi.wdata;
  assign w_wr_strb = r_w_full  ? r_wstrb  : s_axi.wstrb;

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_awready_nxt  = r_awready;
    w_wready_nxt   = r_wready;
    w_bvalid_nxt   = r_bvalid;
    w_aw_full_nxt  = r_aw_full;
    w_w_full_nxt   = r_w_full;
    w_commit       = 1'b0;
    case (r_wr_state)
      WR_IDLE: begin
        if ((r_aw_full || w_aw_hs) && (r_w_full || w_w_hs)) begin
          w_commit       = 1'b1;
          w_wr_state_nxt = WR_BRESP;
          w_bvalid_nxt   = 1'b1;
          w_aw_full_nxt  = 1'b0;
          w_w_full_nxt   = 1'b0;
          w_awready_nxt  = 1'b0;
          w_wready_nxt   = 1'b0;
        end else begin
          w_aw_full_nxt = r_aw_full || w_aw_hs;
          w_w_full_nxt  = r_w_full || w_w_hs;
          w_awready_nxt = !(r_aw_full || w_aw_hs);
          w_wready_nxt  = !(r_w_full || w_w_hs);
        end
      end
      WR_BRESP: begin
        w_awready_nxt = 1'b0;
        w_wready_nxt  = 1'b0;
        if (s_axi.bready) begin
          w_wr_state_nxt = WR_IDLE;
          w_bvalid_nxt   = 1'b0;
          w_awready_nxt  = 1'b1;
          w_wready_nxt   = 1'b1;
        end
      end
      default: w_wr_state_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_state <= WR_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_aw_full  <= 1'b0;
      r_w_full   <= 1'b0;
      r_awaddr   <= 32'd0;
      r_wdata    <= 32'd0;
      r_wstrb    <= 4'd0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_awready  <= w_awready_nxt;
      r_wready   <= w_wready_nxt;
      r_bvalid   <= w_bvalid_nxt;
      r_aw_full  <= w_aw_full_nxt;
      r_w_full   <= w_w_full_nxt;
      if (w_aw_hs) r_awaddr <= s_axi.awaddr;
      if (w_w_hs) begin
        r_wdata <= s_axi.wdata;
        r_wstrb <= s_axi.wstrb;
      end
    end
  end

  // Non-blocking update keeps a same-edge read sample on the old word.
  always_ff @(posedge clk_i) begin
    if (w_commit && !rst_i && in_range(w_wr_addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wr_strb[b]) r_mem[word_idx(w_wr_addr)][8*b +: 8] <= w_wr_data[8*b +: 8];
      end
    end
  end

  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;

endmodule
`default_nettype wire

// File: doc/axi_lite_sim_mem_responder.md
Name: axi_lite_sim_mem_responder

Overview:
- Simulation-side AXI-lite memory slave that answers the reduced AXI-lite channel set driven by the core wrapper: AR/R, AW/W/B, with no resp, prot or burst fields.
- One instance sits on the instruction port and one on the data port of the core wrapper in the testbench.
- Word-addressed storage is backed by a register array.
- Independent read and write engines; one outstanding transaction per channel.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words stored.
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.
- READ_LATENCY, 1, cycles from AR handshake to rvalid assertion; legal range 1..15.
- OOR_RDATA, 32'hDEAD_BEEF, data returned for out-of-range reads.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_araddr  in  32  read byte address.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- s_axi_rdata  out  32  read data.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_awaddr  in  32  write byte address.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte enables; bit i covers wdata[8i+7:8i].
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.

Behaviour:
- Reset (rst_i high at a clock edge):
  - All outputs are registered and go to 0: arready, awready, wready, rvalid, bvalid, rdata.
  - Both FSMs return to IDLE and the AW/W holding buffers are cleared.
  - Memory contents are not cleared.
  - Reset asserted mid-transaction abandons that transaction: no rvalid/bvalid is produced, and a pending write is not committed.
- Address decode:
  - idx = (addr - BASE_ADDR) >> 2, computed in 32-bit wrap-around arithmetic; addr[1:0] is ignored.
  - In range only when (addr - BASE_ADDR) < DEPTH_WORDS*4.
- Read FSM (IDLE, WAIT, RESP):
  - IDLE: arready = 1 (registered; first high one cycle after reset release). The AR handshake (arvalid & arready) captures araddr and loads the latency counter with READ_LATENCY-1.
  - On the handshake, go to RESP if READ_LATENCY == 1, otherwise to WAIT. arready drops to 0 in the next cycle.
  - WAIT: the counter decrements each cycle; at 0, move to RESP.
  - Entering RESP: rdata is sampled from mem[idx], or OOR_RDATA if out of range. rvalid = 1 is held, with rdata stable, until rready. On rvalid & rready, return to IDLE with arready = 1 the next cycle.
  - READ_LATENCY = 1 gives rvalid in the cycle after the handshake.
- Write path:
  - AW and W are accepted independently, in either order.
  - awready = 1 while the AW buffer is empty and the write FSM is IDLE; wready uses the same rule with the W buffer.
  - In IDLE with both buffers empty, awready = wready = 1 simultaneously. The core wrapper's grant depends on arready & awready & wready all being high.
- Write FSM (IDLE, BRESP):
  - The commit edge is the first edge at which both AW and W are held. This includes the same-cycle case, where both handshakes complete together.
  - On that edge: write the enabled bytes of mem[idx]; out-of-range writes are silently dropped. Then set bvalid = 1, clear both buffers and go to BRESP.
  - bvalid is therefore visible one cycle after the later of the two handshakes.
  - BRESP: awready = wready = 0. Hold bvalid until bready, then return to IDLE.
  - wstrb = 0: the commit completes and bvalid is returned, but memory is unchanged.
- Read/write interaction:
  - The read and write engines run concurrently.
  - If a write commit and a read's RESP-entry sample hit the same word on the same edge, the read returns the pre-write data.
- Valid signals never drop without the matching ready. Inputs arriving while a ready is 0 are ignored, not buffered.
- Simulation preload: the array is preloadable via $readmemh from the testbench. The RTL exposes no port for this.

Test Plan:
1. Reset, then one idle cycle → arready = awready = wready = 1 on cycle 2 after release; rvalid = bvalid = 0 throughout.
2. Write 0x1234_5678 to addr 0x10 with wstrb 0xF (AW and W in the same cycle), then read 0x10 with READ_LATENCY = 3 → bvalid one cycle after the handshake; rvalid exactly 3 cycles after the AR handshake with rdata = 0x1234_5678.
3. Partial write of wdata 0xAABB_CCDD with wstrb 0b0101 over stored 0x1234_5678 → readback 0x12BB_56DD. A further write with wstrb 0 leaves the word unchanged and still returns bvalid.
4. W handshake three cycles before AW → awready stays 1 while wready = 0 after W capture; bvalid one cycle after AW; memory updated.
5. Read addr DEPTH_WORDS*4 (out of range) → rdata = 0xDEAD_BEEF. A write to the same address returns bvalid and leaves word 0 unmodified.
6. Hold rready = 0 for 5 cycles with rvalid high → rdata stable and arready = 0 throughout. Assert rst_i during BRESP → bvalid = 0 on the next cycle and all readies 0, then 1 one cycle after release.
